// File: rtl/anspwm_stage_p.sv
// ANS-PWM error-feedback stage: quantises the top Q_W bits of the target, forwards the
// left-aligned residual and emits the ORDER-th difference in sign-magnitude after DLY stages.
module anspwm_stage_p #(
  parameter int unsigned TGT_W = 32,
  parameter int unsigned Q_W   = 16,
  parameter int unsigned ORDER = 1,
  parameter int unsigned DLY   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [TGT_W-1:0]       A,
  output logic [TGT_W-1:0]       nxttgt,
  output logic                   nxt_valid,
  output logic [Q_W+ORDER-2:0]   C,
  output logic                   Csgn,
  output logic                   out_valid
);

  localparam int unsigned D_W = Q_W + ORDER;      // signed difference width
  localparam int unsigned C_W = Q_W + ORDER - 1;  // magnitude width

  if (ORDER != 1 && ORDER != 2) begin : g_bad_order
    $error("anspwm_stage_p: ORDER must be 1 or 2");
  end
  if (Q_W >= TGT_W) begin : g_bad_qw
    $error("anspwm_stage_p: Q_W must be less than TGT_W");
  end
  if (DLY > 8) begin : g_bad_dly
    $error("anspwm_stage_p: DLY must be 0..8");
  end

  logic [Q_W-1:0]        q_r;
  logic [Q_W-1:0]        q_prev;
  logic signed [Q_W:0]   d1_prev;
  logic signed [Q_W:0]   d1_c;
  logic signed [Q_W+1:0] d2_c;
  logic signed [D_W-1:0] res_c;
  logic [D_W-1:0]        abs_c;

  // Stage 0 of the pipe is the difference register; stage DLY drives the outputs.
  logic [C_W-1:0] p_mag [DLY+1];
  logic           p_sgn [DLY+1];
  logic           p_vld [DLY+1];

  // Quantise stage: capture q and residual on each accepted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r       <= '0;
      nxttgt    <= '0;
      nxt_valid <= 1'b0;
    end else begin
      nxt_valid <= in_valid;
      if (in_valid) begin
        q_r    <= A[TGT_W-1 -: Q_W];
        nxttgt <= A << Q_W;
      end
    end
  end

  // Difference arithmetic; widths chosen so no wrap is possible.
  always_comb begin
    d1_c  = $signed({1'b0, q_r}) - $signed({1'b0, q_prev});
    d2_c  = (Q_W+2)'(d1_c) - (Q_W+2)'(d1_prev);
    res_c = '0;
    if (ORDER == 2) res_c = D_W'(d2_c);
    else            res_c = D_W'(d1_c);
    abs_c = res_c[D_W-1] ? D_W'(-res_c) : D_W'(res_c);
  end

  // Difference register and histories; idle cycles leave them untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_prev   <= '0;
      d1_prev  <= '0;
      p_mag[0] <= '0;
      p_sgn[0] <= 1'b0;
      p_vld[0] <= 1'b0;
    end else begin
      p_vld[0] <= nxt_valid;
      if (nxt_valid) begin
        q_prev   <= q_r;
        d1_prev  <= d1_c;
        p_mag[0] <= C_W'(abs_c);
        p_sgn[0] <= res_c[D_W-1];
      end
    end
  end

  // Alignment delay line, shifting every clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i <= DLY; i++) begin
        p_mag[i] <= '0;
        p_sgn[i] <= 1'b0;
        p_vld[i] <= 1'b0;
      end
    end else begin
      for (int i = 1; i <= DLY; i++) begin
        p_mag[i] <= p_mag[i-1];
        p_sgn[i] <= p_sgn[i-1];
        p_vld[i] <= p_vld[i-1];
      end
    end
  end

  assign C         = p_mag[DLY];
  assign Csgn      = p_sgn[DLY];
  assign out_valid = p_vld[DLY];

endmodule

// File: tb/tb_anspwm_stage_p.sv
// Scoreboard bench for anspwm_stage_p: five instances (order/delay variants) share one
// stimulus stream; each has its own reference model, expectation queue and monitor.
module tb_anspwm_stage_p;

  localparam int unsigned TGT_W = 32;
  localparam int unsigned Q_W   = 16;
  localparam int unsigned N     = 5;

  typedef struct {
    int mag;
    bit sgn;
    int cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [TGT_W-1:0] A = '0;
  int               n_chk = 0;
  int               n_fail = 0;
  int               cyc = 0;
  bit               done = 1'b0;

  always #5 clk = ~clk;
  always @(negedge clk) cyc++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int unsigned O  = (g == 1) ? 2 : 1;
    localparam int unsigned D  = (g == 2) ? 0 : (g == 3) ? 3 : (g == 4) ? 8 : 2;
    localparam int unsigned CW = Q_W + O - 1;

    logic [TGT_W-1:0] nxttgt;
    logic             nxt_valid;
    logic [CW-1:0]    c;
    logic             csgn;
    logic             out_valid;
    exp_t             sb[$];

    anspwm_stage_p #(.TGT_W(TGT_W), .Q_W(Q_W), .ORDER(O), .DLY(D)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .A         (A),
      .nxttgt    (nxttgt),
      .nxt_valid (nxt_valid),
      .C         (c),
      .Csgn      (csgn),
      .out_valid (out_valid)
    );

    // Reference model at the sampling edge, output checks 1 time unit later.
    initial begin
      int         qp, d1p, qv, d1, e, last_mag;
      bit         exp_nv, last_sgn;
      logic [31:0] exp_nxt;
      exp_t       x;
      qp = 0; d1p = 0; last_mag = 0; last_sgn = 1'b0; exp_nxt = '0;
      forever begin
        @(posedge clk);
        exp_nv = 1'b0;
        if (rst) begin
          qp = 0; d1p = 0; last_mag = 0; last_sgn = 1'b0; exp_nxt = '0;
          sb.delete();
        end else if (in_valid) begin
          qv = int'(A[TGT_W-1 -: Q_W]);
          d1 = qv - qp;
          e  = (O == 2) ? d1 - d1p : d1;
          qp = qv; d1p = d1;
          sb.push_back('{mag: (e < 0) ? -e : e, sgn: (e < 0), cyc: cyc});
          exp_nv  = 1'b1;
          exp_nxt = A << Q_W;
        end
        #1;
        check_val($sformatf("i%0d nxt_valid", g), 32'(nxt_valid), 32'(exp_nv));
        check_val($sformatf("i%0d nxttgt", g), nxttgt, exp_nxt);
        if (out_valid) begin
          if (sb.size() == 0) begin
            check_val($sformatf("i%0d spurious out_valid", g), 32'(out_valid), 32'd0);
          end else begin
            x = sb.pop_front();
            last_mag = x.mag;
            last_sgn = x.sgn;
            // in_valid cycle t -> out_valid cycle t+2+DLY
            check_val($sformatf("i%0d latency", g), 32'(cyc - x.cyc + 1), 32'(2 + D));
          end
        end
        check_val($sformatf("i%0d C", g), 32'(c), 32'(last_mag));
        check_val($sformatf("i%0d Csgn", g), 32'(csgn), 32'(last_sgn));
      end
    end

    // Asynchronous reset must clear outputs before any clock edge.
    initial forever begin
      @(posedge rst);
      #1;
      check_val($sformatf("i%0d rst out_valid", g), 32'(out_valid), 32'd0);
      check_val($sformatf("i%0d rst C", g), 32'(c), 32'd0);
      check_val($sformatf("i%0d rst Csgn", g), 32'(csgn), 32'd0);
      check_val($sformatf("i%0d rst nxttgt", g), nxttgt, 32'd0);
    end

    initial begin
      wait (done);
      check_val($sformatf("i%0d results left", g), 32'(sb.size()), 32'd0);
    end
  end

  task automatic send(input logic [31:0] a);
    @(negedge clk);
    in_valid = 1'b1;
    A = a;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      A = $urandom;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    // Back-to-back, q = 3,5,1
    send(32'h0003_8000); send(32'h0005_0000); send(32'h0001_0000);
    idle(12);
    // Gapped pattern 1,0,0,1,1 with q = 1,4,2
    pulse_reset();
    send(32'h0001_1234); idle(2); send(32'h0004_0000); send(32'h0002_ABCD);
    idle(12);
    // q stream 0,5,5,2
    pulse_reset();
    send(32'h0000_0000); send(32'h0005_0000); send(32'h0005_FFFF); send(32'h0002_0000);
    idle(12);
    // Full-scale swing 0xFFFF,0x0000
    pulse_reset();
    send(32'hFFFF_0001); send(32'h0000_8000);
    idle(12);
    // Reset with samples in flight, then q = 7
    send($urandom); send($urandom); send($urandom);
    pulse_reset();
    send(32'h0007_0000);
    idle(12);
    // Random traffic with random gaps
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) != 0) send($urandom);
      else idle(1);
    end
    idle(15);
    done = 1'b1;
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
